crossgrid_arb: RTL and testbench
================================

Name: crossgrid_arb

Overview:
- Registered, arbitrated NxN crossbar switch; successor to the static control-word crossgrid.
- Routing comes from a per-input destination field, not an external ctr matrix.
- Contention on an output is resolved by a per-output round-robin arbiter; each output has a one-entry valid/ready register stage.
- Sits between N producer ports and N consumer ports in the datapath fabric.

Parameters:
- number_ports, 4, number of input ports and of output ports (N >= 2).
- data_width, 8, bits per data beat.
- dest_width, $clog2(number_ports), width of the destination and source index fields; localparam, not overridable.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-input beat valid.
- in_data  input  N*data_width  input beats; port i at [i*data_width +: data_width].
- in_dest  input  N*dest_width  destination output index per input.
- in_last  input  N  last beat of packet; used only with the optional feature, otherwise ignored.
- in_ready  output  N  beat on input i accepted this cycle.
- out_valid  output  N  output register j holds a beat.
- out_data  output  N*data_width  output beats, same packing as in_data.
- out_src  output  N*dest_width  index of the input that supplied each out beat.
- out_ready  input  N  consumer on output j takes the beat this cycle.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, all arbiter pointers=0, all locks cleared.
  - in_ready=0 while rst=1.
  - Beats in flight at reset are lost; no partial state survives.
- Request: req[j][i] = in_valid[i] & (in_dest[i]==j).
  - in_dest >= number_ports (non-power-of-2 N) is accepted with in_ready=1 and discarded.
- Output j can load when !out_valid[j] | out_ready[j].
- Arbitration: grant[j] is one-hot among req[j].
  - Search starts at ptr[j] and wraps modulo N.
  - On an accepted beat: ptr[j] <= granted+1; if granted==N-1, ptr[j] wraps to 0.
  - The pointer is unchanged when there is no grant or the output cannot load.
- in_ready[i] = grant[in_dest[i]][i] & can_load[in_dest[i]].
  - in_ready is combinational from in_valid/in_dest/out_ready; no registered ready.
- Transfer: on an accepted beat, out_data[j] <= in_data[i], out_src[j] <= i, out_valid[j] <= 1.
  - Latency is 1 cycle from acceptance to out_valid.
- Output handshake: out_valid[j] clears when out_ready[j]=1 and no new beat loads.
  - Simultaneous drain and load keeps out_valid=1 with the new beat.
  - Throughput is one beat per cycle per output.
- Data and out_src stay stable while out_valid=1 and out_ready=0.
- Independent outputs transfer in parallel; N disjoint routes give N beats per cycle.

Optional Feature:
- Macro CROSSGRID_PKT_LOCK_EN.
- Defined (packet lock):
  - When output j accepts a beat from input i with in_last[i]=0, lock[j] <= 1 and owner[j] <= i.
  - While lock[j]=1, only owner[j] may be granted on j; ptr[j] does not advance.
  - An accepted beat with in_last=1 clears lock[j] and sets ptr[j] <= owner+1.
  - in_dest must be held constant within a packet.
- Undefined: in_last is ignored and arbitration is per beat; lock/owner registers are not instantiated.

Decomposition:
- Package crossgrid_pkg holds the index_t typedef for dest/src indices and a helper function wrap_inc(idx, N) for pointer wrap.
- Sub-module rr_arbiter(clk, rst, req[N], advance, grant[N]), one instance per output, owns ptr.
  - Lock logic stays in crossgrid_arb and masks req before the arbiter.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0; first grant after release goes to input 0.
- Parallel routes: N=4, inputs 0..3 send 0xA0..0xA3 to dest 3,2,1,0 with out_ready=1 -> next cycle out_data[3]=0xA0, out_src[3]=0, and likewise for the other outputs; all in_ready=1.
- Round-robin: inputs 0,1,2 all target output 1 continuously with out_ready=1 -> grant order 0,1,2,0,1,2; each input gets exactly 1 of every 3 beats.
- Backpressure: out_ready[2]=0 for 5 cycles after one beat 0x55 lands -> out_data[2] holds 0x55, in_ready to dest 2 is 0 after the first beat; on release, the next beat appears 1 cycle later without a bubble.
- Lock (macro on): input 1 sends 3-beat packet to output 0 while input 2 contends -> beats 1,1,1 then 2; without macro -> interleaved 1,2,1,2...
- Mid-packet reset (macro on): rst pulse after beat 2 of 4 -> lock cleared, ptr=0, out_valid=0; new packet from input 3 is granted immediately.

Source files
------------

// File: rtl/crossgrid_pkg.sv
// rtl/crossgrid_pkg.sv - shared index type and pointer wrap helper for the crossgrid switch
package crossgrid_pkg;

  // Wide enough for any practical port count; users slice down to dest_width.
  localparam int unsigned INDEX_BITS = 8;

  typedef logic [INDEX_BITS-1:0] index_t;

  function automatic index_t wrap_inc(input index_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + index_t'(1);
  endfunction

endpackage

// File: rtl/crossgrid_arb_rr_arbiter.sv
// rtl/crossgrid_arb_rr_arbiter.sv - per-output round-robin arbiter owning its search pointer
module rr_arbiter
  import crossgrid_pkg::*;
#(
  parameter int number_ports = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [number_ports-1:0] req,
  input  logic                    advance,
  output logic [number_ports-1:0] grant
);

  index_t ptr;
  index_t grant_idx;
  logic   found;
  int     cand;

  // Search begins at ptr and wraps; first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < number_ports; k++) begin
      cand = int'(ptr) + k;
      if (cand >= number_ports) cand = cand - number_ports;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = index_t'(cand);
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= wrap_inc(grant_idx, number_ports);
    end
  end

endmodule

// File: rtl/crossgrid_arb.sv
// rtl/crossgrid_arb.sv - registered NxN crossbar with per-output round-robin arbitration
// Optional packet lock enabled by defining CROSSGRID_PKT_LOCK_EN.
module crossgrid_arb
  import crossgrid_pkg::*;
#(
  parameter int number_ports = 4,
  parameter int data_width   = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [number_ports-1:0]                               in_valid,
  input  logic [number_ports*data_width-1:0]                    in_data,
  input  logic [number_ports*$clog2(number_ports)-1:0]          in_dest,
  input  logic [number_ports-1:0]                               in_last,
  output logic [number_ports-1:0]                               in_ready,
  output logic [number_ports-1:0]                               out_valid,
  output logic [number_ports*data_width-1:0]                    out_data,
  output logic [number_ports*$clog2(number_ports)-1:0]          out_src,
  input  logic [number_ports-1:0]                               out_ready
);

  localparam int dest_width = $clog2(number_ports);

  logic [number_ports-1:0] req   [number_ports];
  logic [number_ports-1:0] req_m [number_ports];
  logic [number_ports-1:0] grant [number_ports];
  logic [number_ports-1:0] can_load;
  logic [number_ports-1:0] accept;
  logic [number_ports-1:0] advance;
  index_t                  gsrc  [number_ports];
  int                      dsel;

  always_comb begin
    for (int j = 0; j < number_ports; j++) begin
      for (int i = 0; i < number_ports; i++) begin
        req[j][i] = in_valid[i] && (int'(in_dest[i*dest_width +: dest_width]) == j);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < number_ports; j++) begin
      can_load[j] = !out_valid[j] || out_ready[j];
      accept[j]   = !rst && can_load[j] && (|grant[j]);
      gsrc[j]     = '0;
      for (int i = 0; i < number_ports; i++) begin
        if (grant[j][i]) gsrc[j] = index_t'(i);
      end
    end
  end

`ifdef CROSSGRID_PKT_LOCK_EN
  logic [number_ports-1:0] lock;
  index_t                  owner [number_ports];

  // A locked output only sees its owner; the pointer moves only at packet end.
  always_comb begin
    for (int j = 0; j < number_ports; j++) begin
      req_m[j]   = lock[j] ? (req[j] & ({{(number_ports-1){1'b0}}, 1'b1} << owner[j])) : req[j];
      advance[j] = accept[j] && in_last[gsrc[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= '0;
      for (int j = 0; j < number_ports; j++) owner[j] <= '0;
    end else begin
      for (int j = 0; j < number_ports; j++) begin
        if (accept[j]) begin
          lock[j]  <= !in_last[gsrc[j]];
          owner[j] <= gsrc[j];
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;

  always_comb begin
    for (int j = 0; j < number_ports; j++) begin
      req_m[j]   = req[j];
      advance[j] = accept[j];
    end
  end
`endif

  for (genvar j = 0; j < number_ports; j++) begin : g_arb
    rr_arbiter #(.number_ports(number_ports)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_m[j]),
      .advance (advance[j]),
      .grant   (grant[j])
    );
  end

  // Out-of-range destinations are accepted and dropped so the producer never stalls.
  always_comb begin
    in_ready = '0;
    dsel     = 0;
    for (int i = 0; i < number_ports; i++) begin
      dsel = int'(in_dest[i*dest_width +: dest_width]);
      if (rst) begin
        in_ready[i] = 1'b0;
      end else if (dsel >= number_ports) begin
        in_ready[i] = in_valid[i];
      end else begin
        in_ready[i] = grant[dsel][i] && can_load[dsel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int j = 0; j < number_ports; j++) begin
        if (accept[j]) begin
          out_valid[j]                          <= 1'b1;
          out_data[j*data_width +: data_width]  <= in_data[int'(gsrc[j])*data_width +: data_width];
          out_src[j*dest_width +: dest_width]   <= gsrc[j][dest_width-1:0];
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crossgrid_arb.sv
// tb/tb_crossgrid_arb.sv - directed self-checking bench for crossgrid_arb
module tb_crossgrid_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_dest;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_src;
  logic [3:0]  out_ready;

  int n_vec = 0;
  int n_bad = 0;

  crossgrid_arb #(.number_ports(4), .data_width(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          rr_exp [6] = '{0, 1, 2, 0, 1, 2};
  int          lk_exp [4];
  int          beat;
  logic        acc1;

  initial begin
`ifdef CROSSGRID_PKT_LOCK_EN
    lk_exp = '{1, 1, 1, 2};
`else
    lk_exp = '{1, 2, 1, 2};
`endif
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = 32'h13121110;
    in_dest   = 8'h00;
    in_last   = 4'hF;
    out_ready = 4'hF;

    // Reset with every input requesting output 0
    step();
    step();
    check_vec("rst_in_ready", 32'(in_ready), 32'h0);
    check_vec("rst_out_valid", 32'(out_valid), 32'h0);
    check_vec("rst_out_data", out_data, 32'h0);
    check_vec("rst_out_src", 32'(out_src), 32'h0);
    rst = 1'b0;
    #1;
    check_vec("first_grant", 32'(in_ready), 32'h1);
    step();
    check_vec("first_valid0", 32'(out_valid[0]), 32'h1);
    check_vec("first_data0", 32'(out_data[7:0]), 32'h10);
    check_vec("first_src0", 32'(out_src[1:0]), 32'h0);
    check_vec("second_grant", 32'(in_ready), 32'h2);
    in_valid = 4'h0;
    step();
    check_vec("drain_valid", 32'(out_valid), 32'h0);

    // Parallel routes: input i -> output 3-i
    in_valid = 4'hF;
    in_data  = 32'hA3A2A1A0;
    in_dest  = 8'b00_01_10_11;
    #1;
    check_vec("par_ready", 32'(in_ready), 32'hF);
    step();
    in_valid = 4'h0;
    check_vec("par_valid", 32'(out_valid), 32'hF);
    check_vec("par_data", out_data, 32'hA0A1A2A3);
    check_vec("par_src", 32'(out_src), 32'h1B);
    step();

    // Round-robin: inputs 0,1,2 contend for output 1 (ptr now 3)
    in_valid = 4'b0111;
    in_data  = 32'h00B2B1B0;
    in_dest  = 8'b00_01_01_01;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_vec($sformatf("rr_ready%0d", k), 32'(in_ready), 32'(1 << rr_exp[k]));
      step();
      check_vec($sformatf("rr_src%0d", k), 32'(out_src[3:2]), 32'(rr_exp[k]));
      check_vec($sformatf("rr_data%0d", k), 32'(out_data[15:8]), 32'(8'hB0 + rr_exp[k]));
    end
    in_valid = 4'h0;
    step();

    // Backpressure on output 2
    out_ready = 4'b1011;
    in_valid  = 4'b0001;
    in_data   = 32'h00000055;
    in_dest   = 8'b00_00_00_10;
    #1;
    check_vec("bp_first_ready", 32'(in_ready[0]), 32'h1);
    step();
    in_data = 32'h00000066;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_vec($sformatf("bp_stall_ready%0d", k), 32'(in_ready[0]), 32'h0);
      check_vec($sformatf("bp_hold_data%0d", k), 32'(out_data[23:16]), 32'h55);
      check_vec($sformatf("bp_hold_valid%0d", k), 32'(out_valid[2]), 32'h1);
      step();
    end
    out_ready = 4'hF;
    #1;
    check_vec("bp_release_ready", 32'(in_ready[0]), 32'h1);
    step();
    in_valid = 4'h0;
    check_vec("bp_next_valid", 32'(out_valid[2]), 32'h1);
    check_vec("bp_next_data", 32'(out_data[23:16]), 32'h66);
    step();
    check_vec("bp_empty", 32'(out_valid[2]), 32'h0);

    // Packet from input 1 versus single beats from input 2 on output 0
    beat     = 0;
    in_dest  = 8'h00;
    in_valid = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      in_data = {8'h00, 8'hD0, 8'(8'hC0 + beat), 8'h00};
      in_last = {1'b1, 1'b1, (beat == 2), 1'b1};
      #1;
      acc1 = in_ready[1];
      step();
      check_vec($sformatf("lock_src%0d", k), 32'(out_src[1:0]), 32'(lk_exp[k]));
      if (acc1) begin
        beat++;
        if (beat == 3) in_valid[1] = 1'b0;
      end
    end
    in_valid = 4'h0;
    in_last  = 4'hF;
    step();

    // Reset in the middle of a 4-beat packet to output 3
    in_valid = 4'b0010;
    in_dest  = 8'b00_00_11_00;
    in_last  = 4'h0;
    in_data  = 32'h0000E100;
    #1;
    check_vec("mid_first_ready", 32'(in_ready[1]), 32'h1);
    step();
    step();
    rst = 1'b1;
    #1;
    check_vec("mid_rst_ready", 32'(in_ready), 32'h0);
    step();
    check_vec("mid_rst_valid", 32'(out_valid), 32'h0);
    rst      = 1'b0;
    in_valid = 4'b1000;
    in_dest  = 8'b11_00_00_00;
    in_data  = 32'hF3000000;
    #1;
    check_vec("mid_new_ready", 32'(in_ready), 32'h8);
    step();
    in_valid = 4'h0;
    check_vec("mid_new_src", 32'(out_src[7:6]), 32'h3);
    check_vec("mid_new_data", 32'(out_data[31:24]), 32'hF3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
